// File: rtl/host_fifo_arbiter_if.sv
// rtl/host_fifo_arbiter_if.sv - client and host FIFO signal bundle for host_fifo_arbiter
//
// Ports (as seen from the arbiter through modport slave):
//   C0_/C1_WREN, C0_/C1_WRDATA  in   client write strobe and byte
//   C0_/C1_WRFULL               out  client write buffer nearly full
//   C0_/C1_RDEN                 in   client read strobe
//   C0_/C1_RDEMPTY              out  client read buffer empty
//   C0_/C1_RDDATA               out  client read byte, valid the cycle after RDEN
//   WREN, WRDATA                out  host write FIFO strobe and byte
//   WRFULL                      in   host write FIFO full
//   RDEN                        out  host read FIFO strobe
//   RDEMPTY, RDDATA             in   host read FIFO empty and byte
// The master modport is the mirror image, used by whatever drives the clients and host FIFO.
interface host_fifo_arbiter_if;
    logic       C0_WREN;
    logic       C1_WREN;
    logic [7:0] C0_WRDATA;
    logic [7:0] C1_WRDATA;
    logic       C0_WRFULL;
    logic       C1_WRFULL;
    logic       C0_RDEN;
    logic       C1_RDEN;
    logic       C0_RDEMPTY;
    logic       C1_RDEMPTY;
    logic [7:0] C0_RDDATA;
    logic [7:0] C1_RDDATA;
    logic       WREN;
    logic [7:0] WRDATA;
    logic       WRFULL;
    logic       RDEN;
    logic       RDEMPTY;
    logic [7:0] RDDATA;

    modport slave (
        input  C0_WREN, C1_WREN, C0_WRDATA, C1_WRDATA,
        output C0_WRFULL, C1_WRFULL,
        input  C0_RDEN, C1_RDEN,
        output C0_RDEMPTY, C1_RDEMPTY, C0_RDDATA, C1_RDDATA,
        output WREN, WRDATA,
        input  WRFULL,
        output RDEN,
        input  RDEMPTY, RDDATA
    );

    modport master (
        output C0_WREN, C1_WREN, C0_WRDATA, C1_WRDATA,
        input  C0_WRFULL, C1_WRFULL,
        output C0_RDEN, C1_RDEN,
        input  C0_RDEMPTY, C1_RDEMPTY, C0_RDDATA, C1_RDDATA,
        input  WREN, WRDATA,
        output WRFULL,
        input  RDEN,
        output RDEMPTY, RDDATA
    );
endinterface

// File: rtl/host_fifo_arbiter.sv
// rtl/host_fifo_arbiter.sv - two-client packet arbiter/router in front of the host byte FIFO pair
//
// Ports:
//   CLK    in  clock
//   RESET  in  asynchronous active-high reset
//   bus    host_fifo_arbiter_if.slave: client write/read FIFO ports and host FIFO ports
// Write side: per-client byte buffers, round-robin packet-atomic merge into the host write
// FIFO with header bit 7 stamped by the source index.
// Read side: host packets are parsed, the header stripped and the payload routed to the
// client named by header bit 7.
module host_fifo_arbiter #(
    parameter int BUF_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    host_fifo_arbiter_if.slave bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] NEAR_C  = CW'(BUF_DEPTH - 1);

    // Length code 7 is the only non-linear code: it means 8 bytes.
    function automatic logic [3:0] payload_len(input logic [2:0] code);
        payload_len = (code == 3'd7) ? 4'd8 : {1'b0, code};
    endfunction

    // ---------------- client write buffers ----------------
    logic [1:0]         cw_en;
    logic [1:0][7:0]    cw_data;
    logic [1:0]         wb_pop;
    logic [1:0][7:0]    wb_head;
    logic [1:0][CW-1:0] wb_cnt;

    assign cw_en   = {bus.C1_WREN, bus.C0_WREN};
    assign cw_data = {bus.C1_WRDATA, bus.C0_WRDATA};

    for (genvar g = 0; g < 2; g++) begin : g_wbuf
        logic [7:0]    mem [BUF_DEPTH];
        logic [AW-1:0] wp;
        logic [AW-1:0] rp;
        logic [CW-1:0] cnt;
        logic          push;

        // A write into a completely full buffer is dropped so queued bytes stay intact.
        assign push = cw_en[g] && (cnt != DEPTH_C);

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push)      wp <= wp + 1'b1;
                if (wb_pop[g]) rp <= rp + 1'b1;
                cnt <= cnt + CW'(push) - CW'(wb_pop[g]);
            end
        end

        always_ff @(posedge CLK) begin
            if (push) mem[wp] <= cw_data[g];
        end

        assign wb_head[g] = mem[rp];
        assign wb_cnt[g]  = cnt;
    end

    // One byte of margin: clients act on WRFULL a cycle late.
    assign bus.C0_WRFULL = (wb_cnt[0] >= NEAR_C);
    assign bus.C1_WRFULL = (wb_cnt[1] >= NEAR_C);

    // ---------------- write arbiter ----------------
    typedef enum logic {W_IDLE, W_XFER} wstate_t;

    wstate_t    w_state, w_state_nx;
    logic       w_gnt, w_gnt_nx;
    logic       w_prio, w_prio_nx;     // client that wins a tie
    logic [3:0] w_rem, w_rem_nx;       // bytes left in packet, header included
    logic       w_first, w_first_nx;   // next byte sent is the header
    logic       wr_en;
    logic [7:0] wr_data;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            w_state <= W_IDLE;
            w_gnt   <= 1'b0;
            w_prio  <= 1'b0;
            w_rem   <= 4'd0;
            w_first <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            w_gnt   <= w_gnt_nx;
            w_prio  <= w_prio_nx;
            w_rem   <= w_rem_nx;
            w_first <= w_first_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        w_gnt_nx   = w_gnt;
        w_prio_nx  = w_prio;
        w_rem_nx   = w_rem;
        w_first_nx = w_first;
        wb_pop     = 2'b00;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        case (w_state)
            W_IDLE: begin
                if (wb_cnt[w_prio] != '0) begin
                    w_gnt_nx   = w_prio;
                    w_state_nx = W_XFER;
                end else if (wb_cnt[~w_prio] != '0) begin
                    w_gnt_nx   = ~w_prio;
                    w_state_nx = W_XFER;
                end
                if (w_state_nx == W_XFER) begin
                    w_rem_nx   = 4'd1 + payload_len(wb_head[w_gnt_nx][6:4]);
                    w_prio_nx  = ~w_gnt_nx;
                    w_first_nx = 1'b1;
                end
            end
            W_XFER: begin
                // Grant is held until the whole packet has gone, even if the buffer runs dry.
                if ((wb_cnt[w_gnt] != '0) && !bus.WRFULL) begin
                    wr_en          = 1'b1;
                    wr_data        = w_first ? {w_gnt, wb_head[w_gnt][6:0]} : wb_head[w_gnt];
                    wb_pop[w_gnt]  = 1'b1;
                    w_first_nx     = 1'b0;
                    w_rem_nx       = w_rem - 4'd1;
                    if (w_rem == 4'd1) w_state_nx = W_IDLE;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    assign bus.WREN   = wr_en;
    assign bus.WRDATA = wr_data;

    // ---------------- read router ----------------
    typedef enum logic {R_HDR, R_PAY} rstate_t;

    rstate_t            r_state, r_state_nx;
    logic               r_dest, r_dest_nx;
    logic [3:0]         r_rem, r_rem_nx;
    logic               inflight;        // host byte returns this cycle
    logic               rd_en;
    logic [1:0]         rb_push;
    logic [1:0][CW-1:0] rb_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= R_HDR;
            r_dest   <= 1'b0;
            r_rem    <= 4'd0;
            inflight <= 1'b0;
        end else begin
            r_state  <= r_state_nx;
            r_dest   <= r_dest_nx;
            r_rem    <= r_rem_nx;
            inflight <= rd_en;
        end
    end

    always_comb begin
        r_state_nx = r_state;
        r_dest_nx  = r_dest;
        r_rem_nx   = r_rem;
        rd_en      = 1'b0;
        rb_push    = 2'b00;
        case (r_state)
            R_HDR: begin
                rd_en = !bus.RDEMPTY && !inflight;
                if (inflight) begin
                    r_dest_nx = bus.RDDATA[7];
                    r_rem_nx  = payload_len(bus.RDDATA[6:4]);
                    if (r_rem_nx != 4'd0) r_state_nx = R_PAY;
                end
            end
            R_PAY: begin
                // Room is checked at issue; only one byte is ever outstanding.
                rd_en = !bus.RDEMPTY && !inflight && (rb_cnt[r_dest] != DEPTH_C);
                if (inflight) begin
                    rb_push[r_dest] = 1'b1;
                    r_rem_nx        = r_rem - 4'd1;
                    if (r_rem == 4'd1) r_state_nx = R_HDR;
                end
            end
            default: r_state_nx = R_HDR;
        endcase
    end

    // Held low while reset is asserted so the host FIFO is never strobed during reset.
    assign bus.RDEN = rd_en && !RESET;

    // ---------------- client read buffers ----------------
    logic [1:0]      cr_en;
    logic [1:0]      rb_empty;
    logic [1:0][7:0] rb_data;

    assign cr_en = {bus.C1_RDEN, bus.C0_RDEN};

    for (genvar g = 0; g < 2; g++) begin : g_rbuf
        logic [7:0]    mem [BUF_DEPTH];
        logic [AW-1:0] wp;
        logic [AW-1:0] rp;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          pop;
        logic          empty;
        logic [7:0]    data;

        assign pop    = cr_en[g] && (cnt != '0);
        assign cnt_nx = cnt + CW'(rb_push[g]) - CW'(pop);

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                wp    <= '0;
                rp    <= '0;
                cnt   <= '0;
                empty <= 1'b1;
                data  <= 8'h00;
            end else begin
                if (rb_push[g]) wp <= wp + 1'b1;
                if (pop) begin
                    rp   <= rp + 1'b1;
                    data <= mem[rp];
                end
                cnt   <= cnt_nx;
                empty <= (cnt_nx == '0);
            end
        end

        always_ff @(posedge CLK) begin
            if (rb_push[g]) mem[wp] <= bus.RDDATA;
        end

        assign rb_cnt[g]   = cnt;
        assign rb_empty[g] = empty;
        assign rb_data[g]  = data;
    end

    assign bus.C0_RDEMPTY = rb_empty[0];
    assign bus.C1_RDEMPTY = rb_empty[1];
    assign bus.C0_RDDATA  = rb_data[0];
    assign bus.C1_RDDATA  = rb_data[1];
endmodule

// File: tb/tb_host_fifo_arbiter.sv
// tb/tb_host_fifo_arbiter.sv - directed self-checking bench for host_fifo_arbiter
module tb_host_fifo_arbiter;
    logic CLK = 1'b0;
    logic RESET;

    host_fifo_arbiter_if bus();

    host_fifo_arbiter #(.BUF_DEPTH(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge CLK) cyc++;

    // Host write FIFO capture
    logic [7:0] wq[$];
    int         wt[$];
    int         wren_full = 0;

    always @(negedge CLK) begin
        if (bus.WREN === 1'b1) begin
            if (bus.WRFULL) wren_full++;
            wq.push_back(bus.WRDATA);
            wt.push_back(cyc);
        end
    end

    // Host read FIFO model: RDDATA valid the cycle after RDEN
    logic [7:0] rom [8];
    int         rd_len = 0;
    int         rd_idx = 0;
    logic       rden_s = 1'b0;

    assign bus.RDEMPTY = (rd_idx >= rd_len);

    always @(negedge CLK) rden_s = bus.RDEN;

    always @(posedge CLK) begin
        if (rden_s) begin
            #1;
            bus.RDDATA = rom[rd_idx];
            rd_idx++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cw(input bit c, input logic [7:0] d);
        if (c) begin bus.C1_WREN = 1'b1; bus.C1_WRDATA = d; end
        else   begin bus.C0_WREN = 1'b1; bus.C0_WRDATA = d; end
        tick(1);
        bus.C0_WREN = 1'b0;
        bus.C1_WREN = 1'b0;
    endtask

    task automatic cw2(input logic [7:0] d0, input logic [7:0] d1);
        bus.C0_WREN = 1'b1; bus.C0_WRDATA = d0;
        bus.C1_WREN = 1'b1; bus.C1_WRDATA = d1;
        tick(1);
        bus.C0_WREN = 1'b0;
        bus.C1_WREN = 1'b0;
    endtask

    task automatic rd(input bit c, output logic [7:0] v);
        if (c) bus.C1_RDEN = 1'b1;
        else   bus.C0_RDEN = 1'b1;
        tick(1);
        bus.C0_RDEN = 1'b0;
        bus.C1_RDEN = 1'b0;
        v = c ? bus.C1_RDDATA : bus.C0_RDDATA;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({bus.WREN, bus.RDEN, bus.WRDATA} !== 10'b0) begin
            errors++;
            $display("FAIL reset_host_out: got WREN=%b RDEN=%b WRDATA=%h want 0 0 00", bus.WREN, bus.RDEN, bus.WRDATA);
        end
        checks++;
        if ({bus.C0_RDDATA, bus.C1_RDDATA} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rddata: got %h %h want 00 00", bus.C0_RDDATA, bus.C1_RDDATA);
        end
        checks++;
        if ({bus.C0_WRFULL, bus.C1_WRFULL, bus.C0_RDEMPTY, bus.C1_RDEMPTY} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0011",
                     {bus.C0_WRFULL, bus.C1_WRFULL, bus.C0_RDEMPTY, bus.C1_RDEMPTY});
        end
        @(posedge CLK);
        #1 RESET = 1'b0;
        tick(2);
    endtask

    task automatic test_single;
        logic [7:0] exp [5];
        int base;
        exp = '{8'h42, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        base = wq.size();
        for (int i = 0; i < 5; i++) cw(0, exp[i]);
        tick(10);
        checks++;
        if (wq.size() - base != 5) begin
            errors++;
            $display("FAIL single_count: got %0d want 5", wq.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wq[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL single_byte%0d: got %h want %h", i, wq[base+i], exp[i]);
                end
            end
            checks++;
            if (wt[base+4] - wt[base] != 4) begin
                errors++;
                $display("FAIL single_consecutive: got span %0d want 4", wt[base+4] - wt[base]);
            end
        end
    endtask

    task automatic test_long;
        logic [7:0] exp [9];
        int base;
        exp = '{8'hF2, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        base = wq.size();
        cw(1, 8'h72);
        for (int i = 1; i < 9; i++) cw(1, exp[i]);
        tick(12);
        checks++;
        if (wq.size() - base != 9) begin
            errors++;
            $display("FAIL long_count: got %0d want 9", wq.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wq[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL long_byte%0d: got %h want %h", i, wq[base+i], exp[i]);
                end
            end
            checks++;
            if (wt[base+8] - wt[base] != 8) begin
                errors++;
                $display("FAIL long_consecutive: got span %0d want 8", wt[base+8] - wt[base]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp [19];
        int base;
        exp = '{8'h50, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                8'hD0, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                8'h00,
                8'hA0, 8'h41, 8'h42, 8'h20, 8'h31, 8'h32};
        base = wq.size();
        cw2(8'h50, 8'h50);
        for (int i = 1; i < 6; i++) cw2(8'(i), 8'(8'h10 + i));
        tick(20);
        cw(0, 8'h00);
        tick(5);
        cw2(8'h20, 8'h20);
        cw2(8'h31, 8'h41);
        cw2(8'h32, 8'h42);
        tick(15);
        checks++;
        if (wq.size() - base != 19) begin
            errors++;
            $display("FAIL rr_count: got %0d want 19", wq.size() - base);
        end else begin
            for (int i = 0; i < 19; i++) begin
                checks++;
                if (wq[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rr_byte%0d: got %h want %h", i, wq[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] exp [10];
        int base;
        exp = '{8'h50, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'hB0, 8'h71, 8'h72, 8'h73};
        bus.WRFULL = 1'b1;
        base = wq.size();
        for (int i = 0; i < 6; i++) cw(0, exp[i]);
        cw(1, 8'h30);
        for (int i = 7; i < 10; i++) cw(1, exp[i]);
        tick(2);
        checks++;
        if (wq.size() != base) begin
            errors++;
            $display("FAIL stall_blocked: got %0d bytes want 0", wq.size() - base);
        end
        bus.WRFULL = 1'b0;
        tick(2);
        bus.WRFULL = 1'b1;
        tick(3);
        bus.WRFULL = 1'b0;
        tick(15);
        checks++;
        if (wq.size() - base != 10) begin
            errors++;
            $display("FAIL stall_count: got %0d want 10", wq.size() - base);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (wq[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL stall_byte%0d: got %h want %h", i, wq[base+i], exp[i]);
                end
            end
            checks++;
            if (wt[base+2] - wt[base+1] != 4) begin
                errors++;
                $display("FAIL stall_gap: got %0d want 4", wt[base+2] - wt[base+1]);
            end
        end
        checks++;
        if (wren_full != 0) begin
            errors++;
            $display("FAIL wren_while_full: got %0d want 0", wren_full);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp [8];
        int base;
        exp = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'h80};
        bus.WRFULL = 1'b1;
        base = wq.size();
        cw(1, 8'h60);
        for (int i = 1; i < 6; i++) cw(1, exp[i]);
        checks++;
        if (bus.C1_WRFULL !== 1'b0) begin
            errors++;
            $display("FAIL wrfull_at_6: got %b want 0", bus.C1_WRFULL);
        end
        cw(1, 8'hE6);
        checks++;
        if (bus.C1_WRFULL !== 1'b1) begin
            errors++;
            $display("FAIL wrfull_at_7: got %b want 1", bus.C1_WRFULL);
        end
        cw(1, 8'h00);
        cw(1, 8'hEE);
        bus.WRFULL = 1'b0;
        tick(20);
        checks++;
        if (wq.size() - base != 8) begin
            errors++;
            $display("FAIL overflow_count: got %0d want 8", wq.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wq[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL overflow_byte%0d: got %h want %h", i, wq[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (bus.C1_WRFULL !== 1'b0) begin
            errors++;
            $display("FAIL wrfull_drained: got %b want 0", bus.C1_WRFULL);
        end
    endtask

    task automatic test_read_route;
        logic [7:0] v;
        rom[0] = 8'h90; rom[1] = 8'hAB; rom[2] = 8'h20; rom[3] = 8'h11; rom[4] = 8'h22;
        rd_len = 5;
        tick(20);
        checks++;
        if (rd_idx != 5) begin
            errors++;
            $display("FAIL host_reads: got %0d want 5", rd_idx);
        end
        checks++;
        if ({bus.C0_RDEMPTY, bus.C1_RDEMPTY} !== 2'b00) begin
            errors++;
            $display("FAIL route_nonempty: got %b want 00", {bus.C0_RDEMPTY, bus.C1_RDEMPTY});
        end
        rd(0, v);
        checks++;
        if (v !== 8'h11) begin errors++; $display("FAIL c0_read0: got %h want 11", v); end
        rd(0, v);
        checks++;
        if (v !== 8'h22) begin errors++; $display("FAIL c0_read1: got %h want 22", v); end
        checks++;
        if (bus.C0_RDEMPTY !== 1'b1) begin
            errors++;
            $display("FAIL c0_empty_after: got %b want 1", bus.C0_RDEMPTY);
        end
        rd(0, v);
        checks++;
        if (v !== 8'h22) begin errors++; $display("FAIL c0_read_empty_hold: got %h want 22", v); end
        rd(1, v);
        checks++;
        if (v !== 8'hAB) begin errors++; $display("FAIL c1_read0: got %h want AB", v); end
        checks++;
        if (bus.C1_RDEMPTY !== 1'b1) begin
            errors++;
            $display("FAIL c1_empty_after: got %b want 1", bus.C1_RDEMPTY);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] exp [3];
        int base;
        exp = '{8'h10, 8'h77, 8'h80};
        bus.WRFULL = 1'b1;
        base = wq.size();
        cw(0, 8'h60);
        for (int i = 1; i < 7; i++) cw(0, 8'(i));
        checks++;
        if (bus.C0_WRFULL !== 1'b1) begin
            errors++;
            $display("FAIL c0_wrfull: got %b want 1", bus.C0_WRFULL);
        end
        bus.WRFULL = 1'b0;
        tick(2);
        checks++;
        if (bus.WREN !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wren: got %b want 1", bus.WREN);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({bus.WREN, bus.WRDATA, bus.RDEN} !== 10'b0) begin
            errors++;
            $display("FAIL async_host_out: got WREN=%b WRDATA=%h RDEN=%b want 0 00 0", bus.WREN, bus.WRDATA, bus.RDEN);
        end
        checks++;
        if ({bus.C0_WRFULL, bus.C0_RDEMPTY, bus.C1_RDEMPTY} !== 3'b011) begin
            errors++;
            $display("FAIL async_flags: got %b want 011", {bus.C0_WRFULL, bus.C0_RDEMPTY, bus.C1_RDEMPTY});
        end
        checks++;
        if ({bus.C0_RDDATA, bus.C1_RDDATA} !== 16'h0000) begin
            errors++;
            $display("FAIL async_rddata: got %h %h want 00 00", bus.C0_RDDATA, bus.C1_RDDATA);
        end
        checks++;
        if (wq.size() - base != 2) begin
            errors++;
            $display("FAIL partial_sent: got %0d want 2", wq.size() - base);
        end
        tick(2);
        RESET = 1'b0;
        tick(2);
        base = wq.size();
        cw2(8'h10, 8'h00);
        cw(0, 8'h77);
        tick(10);
        checks++;
        if (wq.size() - base != 3) begin
            errors++;
            $display("FAIL post_reset_count: got %0d want 3", wq.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL post_reset_byte%0d: got %h want %h", i, wq[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (wren_full != 0) begin
            errors++;
            $display("FAIL wren_while_full_end: got %0d want 0", wren_full);
        end
    endtask

    initial begin
        RESET         = 1'b1;
        bus.C0_WREN   = 1'b0;
        bus.C1_WREN   = 1'b0;
        bus.C0_WRDATA = 8'h00;
        bus.C1_WRDATA = 8'h00;
        bus.C0_RDEN   = 1'b0;
        bus.C1_RDEN   = 1'b0;
        bus.WRFULL    = 1'b0;
        test_reset;
        test_single;
        test_long;
        test_round_robin;
        test_stall;
        test_overflow;
        test_read_route;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/host_fifo_arbiter.md
Name: host_fifo_arbiter

Overview:
- Sits between up to two AHB3 host-slave/host-master clients and the single host byte FIFO pair (host PC link).
- Write direction: merges client byte streams into one host write FIFO. Packets are atomic. The interface bit (header bit 7) is stamped with the source index.
- Read direction: parses host routing headers, strips them, and delivers the payload to the addressed client's read buffer.
- Each client sees a plain FIFO interface with 1-cycle read latency, identical to a direct host FIFO connection.

Parameters:
- BUF_DEPTH, 8, depth in bytes of each per-client write and read buffer. Power of two, at least 4.

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset, asynchronous, active-high.
- C0_WREN, C1_WREN  input  1  client write strobe.
- C0_WRDATA, C1_WRDATA  input  8  client write byte.
- C0_WRFULL, C1_WRFULL  output  1  client write buffer nearly full.
- C0_RDEN, C1_RDEN  input  1  client read strobe.
- C0_RDEMPTY, C1_RDEMPTY  output  1  client read buffer empty.
- C0_RDDATA, C1_RDDATA  output  8  client read byte, registered, valid the cycle after RDEN.
- WREN  output  1  host write FIFO strobe.
- WRDATA  output  8  host write byte.
- WRFULL  input  1  host write FIFO full.
- RDEN  output  1  host read FIFO strobe.
- RDEMPTY  input  1  host read FIFO empty.
- RDDATA  input  8  host read byte, valid the cycle after RDEN.

Behaviour:
- Reset (asynchronous, RESET=1) clears all buffers, pointers and states.
- Reset values: WREN=0, RDEN=0, WRDATA=0, Cx_RDDATA=0, Cx_WRFULL=0, Cx_RDEMPTY=1.
- A reset mid-packet discards any partial packet. Nothing resumes after reset.
- Length code is header bits [6:4]. Codes 0..6 mean 0..6 payload bytes; code 7 means 8 payload bytes.
- Client write buffers:
  - A byte is accepted on every Cx_WREN, regardless of Cx_WRFULL.
  - Cx_WRFULL = (occupancy >= BUF_DEPTH-1). This leaves one byte of margin because clients sample WRFULL one cycle before writing.
  - A write into a completely full buffer is dropped, and the buffer contents are not corrupted.
- Write arbiter state machine:
  - States: W_IDLE, W_XFER.
  - W_IDLE: a client is eligible when its buffer is non-empty. Its head byte is always a header.
  - Arbitration is round-robin. The last-granted client has lower priority. After reset, C0 has priority.
  - On grant, latch the client index and set remaining = 1 + payload(header), then go to W_XFER.
  - W_XFER: each cycle in which the granted buffer is non-empty and WRFULL=0 (checked combinationally in the same cycle), assert WREN, pop one byte and decrement remaining.
    - The first byte sent is the header with bit 7 replaced by the client index.
    - When remaining reaches 0, return to W_IDLE.
    - The grant must not change mid-packet, even if the buffer runs dry.
  - No bubble is required between packets: W_IDLE to W_XFER takes 1 cycle.
  - WREN is never asserted in a cycle where WRFULL=1.
- Read router state machine:
  - States: R_HDR, R_PAY.
  - At most one host read is in flight. `inflight` is set on RDEN and cleared the next cycle when RDDATA is consumed.
  - R_HDR: RDEN = ~RDEMPTY & ~inflight. On the returned byte:
    - latch dest = bit 7 and rem = payload(code);
    - the header is not forwarded;
    - if rem = 0, stay in R_HDR; otherwise go to R_PAY.
  - R_PAY: RDEN = ~RDEMPTY & ~inflight & (dest buffer has at least 1 free slot). On the returned byte:
    - push it into the dest buffer and decrement rem;
    - when rem reaches 0, go to R_HDR.
- Client read buffers:
  - Cx_RDEMPTY = occupancy==0, registered off the buffer count.
  - Cx_RDEN with an empty buffer is ignored, and Cx_RDDATA holds its value.
  - Push and pop in the same cycle keep the occupancy unchanged.
- Pointers wrap modulo BUF_DEPTH. Occupancy counters are $clog2(BUF_DEPTH)+1 bits wide.

Test Plan:
1. C0 writes 8'h42 followed by 4 address bytes (read header, code 4) while host WRFULL=0 -> the host sees WREN for exactly 5 consecutive cycles: 8'h42, then the addr bytes in order.
2. C1 writes header 8'h72 (code 7, bit 7=0) plus 8 bytes -> the host receives 8'hF2 first, then 8 bytes. Total 9 WREN cycles.
3. Both clients load a 6-byte packet in the same cycle, C0 first after reset -> all 6 C0 bytes are sent before any C1 byte. C1 is sent next. A second pair of simultaneous packets is sent C1 then C0.
4. Host WRFULL is held high for 3 cycles in the middle of a C0 packet while C1 has data -> WREN=0 during the stall and the packet resumes intact. C1's bytes never interleave with C0's.
5. The host read FIFO supplies 8'h90 (dest 1, code 1), 8'hAB, 8'h20 (dest 0, code 2), 8'h11, 8'h22 -> C1 buffer holds {AB} and C0 buffer holds {11,22}. Headers are never visible to clients. C0_RDEN returns 8'h11 and then 8'h22 one cycle after each strobe.
6. Fill C0 to BUF_DEPTH-1 -> C0_WRFULL=1. Assert RESET asynchronously mid-packet -> outputs return to their reset values immediately. After release, the next C0 header is arbitrated cleanly.
